jvm_arm_xlate_engine: RTL and testbench

- Sequential Java-bytecode-to-ARM translator: fetches bytecode bytes from the program ROM, decodes them, and streams 32-bit ARM instruction words out over a valid/ready handshake.
- Successor to the combinational per-opcode encoders. Adds parametrised ROM geometry and local-variable count, operand-byte opcodes, multi-word emit sequences, backpressure, and error/termination reporting.
- Sits between the bytecode ROM and the instruction sink (instruction memory writer or trace capture).

---
 rtl/jvm_arm_xlate_engine.sv | 205 ++++++++++++++++++++
 tb/tb_jvm_arm_xlate_engine.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/jvm_arm_xlate_engine.sv
// rtl/jvm_arm_xlate_engine.sv - sequential Java bytecode to ARM word translator with valid/ready output
// Optional dup/pop support is enabled by defining JAA_STACK_OPS_EN.
module jvm_arm_xlate_engine #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 6,
  parameter int NUM_LOCALS     = 4,
  parameter int LOCAL_BASE_REG = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  instr_valid,
  output logic [31:0]           instr_data,
  input  logic                  instr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_OPERAND, S_EMIT, S_DONE, S_ERROR
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PC_MAX = '1;
  localparam logic [7:0]            NL_B   = 8'(NUM_LOCALS);
  localparam logic [3:0]            BASE_R = 4'(LOCAL_BASE_REG);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    wrap_q, wrap_d;
  logic [7:0]              opcode_q, opcode_d;
  logic [7:0]              operand_q, operand_d;
  logic [2:0]              idx_q, idx_d;
  logic [1:0]              k_q, k_d;
  logic [15:0]             count_q, count_d;

  logic                    op_known, op_operand, op_fixed;
  logic [7:0]              fixed_idx;
  logic [1:0]              last_k;
  logic [31:0]             word;
  logic [3:0]              rl;
  logic [31:0]             rl_bit;
  logic [7:0]              iconst_n;

  // Classify the byte currently on the ROM bus (only meaningful in FETCH).
  always_comb begin
    op_known   = 1'b0;
    op_operand = 1'b0;
    op_fixed   = 1'b0;
    fixed_idx  = 8'd0;
    case (rom_data) inside
      8'h00, 8'h60, 8'h64, 8'hB1: op_known = 1'b1;
      [8'h03:8'h08]:              op_known = 1'b1;
      8'h10, 8'h15, 8'h36: begin
        op_known   = 1'b1;
        op_operand = 1'b1;
      end
      [8'h1A:8'h1D]: begin
        op_known  = 1'b1;
        op_fixed  = 1'b1;
        fixed_idx = rom_data - 8'h1A;
      end
      [8'h3B:8'h3E]: begin
        op_known  = 1'b1;
        op_fixed  = 1'b1;
        fixed_idx = rom_data - 8'h3B;
      end
`ifdef JAA_STACK_OPS_EN
      8'h57, 8'h59:               op_known = 1'b1;
`endif
      default: ;
    endcase
  end

  assign rl       = BASE_R + {1'b0, idx_q};
  assign rl_bit   = 32'd1 << rl;
  assign iconst_n = opcode_q - 8'h03;

  // Word k of the latched opcode's emit sequence, plus the index of its final word.
  always_comb begin
    word   = 32'd0;
    last_k = 2'd0;
    case (opcode_q) inside
      [8'h03:8'h08]: begin
        last_k = 2'd1;
        word   = (k_q == 2'd0) ? (32'hE3A00000 | {24'd0, iconst_n}) : 32'hE92D0001;
      end
      8'h10: begin
        last_k = 2'd1;
        if (k_q != 2'd0)       word = 32'hE92D0001;
        else if (operand_q[7]) word = 32'hE3E00000 | {24'd0, ~operand_q};
        else                   word = 32'hE3A00000 | {24'd0, operand_q};
      end
      8'h15, [8'h1A:8'h1D]: word = 32'hE92D0000 | rl_bit;
      8'h36, [8'h3B:8'h3E]: word = 32'hE8BD0000 | rl_bit;
      8'h60, 8'h64: begin
        last_k = 2'd3;
        case (k_q)
          2'd0:    word = 32'hE8BD0002;
          2'd1:    word = 32'hE8BD0001;
          2'd2:    word = (opcode_q == 8'h60) ? 32'hE0800001 : 32'hE0400001;
          default: word = 32'hE92D0001;
        endcase
      end
      8'hB1: word = 32'hE12FFF1E;
`ifdef JAA_STACK_OPS_EN
      8'h59: begin
        last_k = 2'd1;
        word   = (k_q == 2'd0) ? 32'hE59D0000 : 32'hE92D0001;
      end
      8'h57: word = 32'hE28DD004;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wrap_d    = wrap_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    idx_d     = idx_q;
    k_d       = k_q;
    count_d   = count_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          wrap_d  = 1'b0;
          count_d = 16'd0;
        end
      end
      S_FETCH: begin
        pc_d     = pc_q + 1'b1;
        wrap_d   = wrap_q | (pc_q == PC_MAX);
        opcode_d = rom_data;
        idx_d    = fixed_idx[2:0];
        k_d      = 2'd0;
        // Only a return may sit at the last address; anything else would run off the end.
        if (wrap_q || !op_known || ((pc_q == PC_MAX) && (rom_data != 8'hB1)) ||
            (op_fixed && (fixed_idx >= NL_B)))
          state_d = S_ERROR;
        else if (rom_data == 8'h00)
          state_d = S_FETCH;
        else if (op_operand)
          state_d = S_OPERAND;
        else
          state_d = S_EMIT;
      end
      S_OPERAND: begin
        pc_d      = pc_q + 1'b1;
        wrap_d    = wrap_q | (pc_q == PC_MAX);
        operand_d = rom_data;
        idx_d     = rom_data[2:0];
        k_d       = 2'd0;
        if ((opcode_q != 8'h10) && (rom_data >= NL_B)) state_d = S_ERROR;
        else                                           state_d = S_EMIT;
      end
      S_EMIT: begin
        if (instr_ready) begin
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          if (k_q == last_k) state_d = (opcode_q == 8'hB1) ? S_DONE : S_FETCH;
          else               k_d     = k_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      wrap_q    <= 1'b0;
      opcode_q  <= 8'd0;
      operand_q <= 8'd0;
      idx_q     <= 3'd0;
      k_q       <= 2'd0;
      count_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      wrap_q    <= wrap_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      idx_q     <= idx_d;
      k_q       <= k_d;
      count_q   <= count_d;
    end
  end

  assign rom_addr    = pc_q;
  assign instr_valid = (state_q == S_EMIT);
  assign instr_data  = instr_valid ? word : 32'd0;
  assign busy        = (state_q == S_FETCH) || (state_q == S_OPERAND) || (state_q == S_EMIT);
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERROR);
  assign instr_count = count_q;

endmodule

// File: tb/tb_jvm_arm_xlate_engine.sv
// tb/tb_jvm_arm_xlate_engine.sv - scoreboard bench for jvm_arm_xlate_engine
module tb_jvm_arm_xlate_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic        instr_ready = 1'b1;
  logic        busy, done, error;
  logic [15:0] instr_count;

  logic [7:0]  rom [64];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          accepted = 0;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  jvm_arm_xlate_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_ready(instr_ready),
    .busy(busy), .done(done), .error(error), .instr_count(instr_count)
  );

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected: got %h, required none", instr_data);
      end else begin
        logic [31:0] w;
        w = exp_q.pop_front();
        if (w !== instr_data) begin
          errors++;
          $display("FAIL word_%0d: got %h, required %h", accepted, instr_data, w);
        end
      end
      accepted++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic load(input logic [7:0] fill, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4, input int n);
    for (int i = 0; i < 64; i++) rom[i] = fill;
    if (n > 0) rom[0] = b0;
    if (n > 1) rom[1] = b1;
    if (n > 2) rom[2] = b2;
    if (n > 3) rom[3] = b3;
    if (n > 4) rom[4] = b4;
  endtask

  task automatic push_prog1();
    exp_q.push_back(32'hE3A00002); exp_q.push_back(32'hE92D0001);
    exp_q.push_back(32'hE3A00003); exp_q.push_back(32'hE92D0001);
    exp_q.push_back(32'hE8BD0002); exp_q.push_back(32'hE8BD0001);
    exp_q.push_back(32'hE0800001); exp_q.push_back(32'hE92D0001);
    exp_q.push_back(32'hE8BD0020); exp_q.push_back(32'hE12FFF1E);
  endtask

  task automatic run(input string name, input int exp_lat, input bit stall,
                     input bit exp_done, input bit exp_err, input int exp_cnt);
    int cyc, lat, stall_cnt;
    lat = -1;
    stall_cnt = 0;
    accepted = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    chk({name, "_start_clears"}, {29'd0, error, done, busy}, 32'd1);
    chk({name, "_count_cleared"}, {16'd0, instr_count}, 32'd0);
    while (cyc < 400) begin
      if (lat < 0 && instr_valid) lat = cyc;
      if (stall && accepted == 2 && instr_valid && stall_cnt < 3) begin
        instr_ready = 1'b0;
        stall_cnt++;
        chk({name, "_stall_hold"}, instr_data, 32'hE3A00003);
      end else begin
        instr_ready = 1'b1;
      end
      if (!busy) break;
      @(posedge clk); #1;
      cyc++;
    end
    instr_ready = 1'b1;
    if (cyc >= 400) begin
      errors++; checks++;
      $display("FAIL %s_timeout: got busy after %0d cycles, required idle", name, cyc);
    end
    if (exp_lat > 0) chk({name, "_latency"}, lat, exp_lat);
    if (stall) chk({name, "_stall_cycles"}, stall_cnt, 3);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_done"}, {31'd0, done}, {31'd0, exp_done});
    chk({name, "_error"}, {31'd0, error}, {31'd0, exp_err});
    chk({name, "_count"}, {16'd0, instr_count}, exp_cnt);
    chk({name, "_sb_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    load(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    #13;
    chk("reset_outputs", {instr_valid, busy, done, error, rom_addr, instr_count},
        32'd0);
    chk("reset_data", instr_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    load(8'h00, 8'h05, 8'h06, 8'h60, 8'h3C, 8'hB1, 5);
    push_prog1();
    run("prog1", 2, 1'b0, 1'b1, 1'b0, 10);

    push_prog1();
    run("prog1_stall", 2, 1'b1, 1'b1, 1'b0, 10);

    load(8'h00, 8'h10, 8'hF6, 8'hB1, 8'h00, 8'h00, 3);
    exp_q.push_back(32'hE3E00009); exp_q.push_back(32'hE92D0001); exp_q.push_back(32'hE12FFF1E);
    run("bipush_neg", 3, 1'b0, 1'b1, 1'b0, 3);

    load(8'h00, 8'h10, 8'h7F, 8'hB1, 8'h00, 8'h00, 3);
    exp_q.push_back(32'hE3A0007F); exp_q.push_back(32'hE92D0001); exp_q.push_back(32'hE12FFF1E);
    run("bipush_pos", 3, 1'b0, 1'b1, 1'b0, 3);

    load(8'h00, 8'h15, 8'h03, 8'h3E, 8'hB1, 8'h00, 4);
    exp_q.push_back(32'hE92D0080); exp_q.push_back(32'hE8BD0080); exp_q.push_back(32'hE12FFF1E);
    run("local3", 3, 1'b0, 1'b1, 1'b0, 3);

    load(8'h00, 8'h15, 8'h05, 8'h00, 8'h00, 8'h00, 2);
    run("iload_oob", 0, 1'b0, 1'b0, 1'b1, 0);

    load(8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    run("bad_op", 0, 1'b0, 1'b0, 1'b1, 0);
    run("bad_op_again", 0, 1'b0, 1'b0, 1'b1, 0);

    load(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    run("nop_fill", 0, 1'b0, 1'b0, 1'b1, 0);

    load(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    rom[63] = 8'hB1;
    exp_q.push_back(32'hE12FFF1E);
    run("ret_last_addr", 0, 1'b0, 1'b1, 1'b0, 1);

    load(8'h00, 8'h59, 8'hB1, 8'h00, 8'h00, 8'h00, 2);
`ifdef JAA_STACK_OPS_EN
    exp_q.push_back(32'hE59D0000); exp_q.push_back(32'hE92D0001); exp_q.push_back(32'hE12FFF1E);
    run("dup", 2, 1'b0, 1'b1, 1'b0, 3);
`else
    run("dup_off", 0, 1'b0, 1'b0, 1'b1, 0);
`endif

    load(8'h00, 8'h05, 8'h06, 8'h60, 8'h3C, 8'hB1, 5);
    push_prog1();
    accepted = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (accepted < 5 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("mid_reset_reached", {31'd0, cyc < 200}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {instr_valid, busy, done, error, rom_addr, instr_count},
        32'd0);
    chk("mid_reset_data", instr_data, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_prog1();
    run("after_reset", 2, 1'b0, 1'b1, 1'b0, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
